lcs_request_master: RTL and testbench

- Initiator side of the LCS request/answer link: issues a frame of NUM_REQ request pulses on req and captures the byte returned on the answer bus after each pulse.
- Writes captured bytes into a double-buffered receive RAM through a simple write port.
- Drives the temperature channel select and flags the temperature slot separately.
- Sits in the host-side controller, one instance per LCS link.

---
 rtl/lcs_pkg.sv | 23 ++
 rtl/lcs_request_master_if.sv | 28 ++
 rtl/lcs_req_timer.sv | 22 ++
 rtl/lcs_request_master.sv | 139 +++++++++++++
 tb/tb_lcs_request_master.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcs_pkg.sv
// Shared LCS link definitions: slot numbering, bus widths and the request FSM states.
package lcs_pkg;

    localparam int unsigned LCS_NUM_REQ   = 123;
    localparam int unsigned LCS_TEMP_SLOT = 122;
    localparam int unsigned LCS_ADDR_W    = 8;
    localparam int unsigned LCS_SLOT_W    = 7;
    localparam int unsigned LCS_DATA_W    = 8;
    localparam int unsigned LCS_SEL_W     = 3;
    localparam int unsigned LCS_CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_GAP,
        ST_DONE
    } lcs_state_e;

    function automatic int unsigned lcs_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcs_request_master_if.sv
// Host-side LCS request link: frame control, responder strobe/answer and receive RAM write port.
interface lcs_request_master_if;
    import lcs_pkg::*;

    logic                  start;
    logic [LCS_DATA_W-1:0] dataRx;
    logic                  req;
    logic [LCS_SEL_W-1:0]  sel;
    logic                  wrEn;
    logic [LCS_ADDR_W-1:0] wrAddr;
    logic [LCS_DATA_W-1:0] wrData;
    logic [LCS_DATA_W-1:0] tempData;
    logic                  tempValid;
    logic                  busy;
    logic                  frameDone;
    logic [LCS_CNT_W-1:0]  frameCnt;

    modport master (
        input  start, dataRx,
        output req, sel, wrEn, wrAddr, wrData, tempData, tempValid, busy, frameDone, frameCnt
    );

    modport slave (
        output start, dataRx,
        input  req, sel, wrEn, wrAddr, wrData, tempData, tempValid, busy, frameDone, frameCnt
    );

endinterface

// File: rtl/lcs_req_timer.sv
// Loadable down-counter that times the req-high and req-low phases.
module lcs_req_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               cnt <= '0;
        else if (load)          cnt <= load_val;
        else if (cnt != '0)     cnt <= cnt - W'(1);
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/lcs_request_master.sv
// LCS link initiator: issues a frame of request pulses and writes each answer byte
// into the current bank of the double-buffered receive RAM.
module lcs_request_master
    import lcs_pkg::*;
#(
    parameter int unsigned NUM_REQ   = LCS_NUM_REQ,
    parameter int unsigned TEMP_SLOT = LCS_TEMP_SLOT,
    parameter int unsigned REQ_HIGH  = 8,
    parameter int unsigned REQ_GAP   = 24,
    parameter int unsigned SEL_MAX   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    lcs_request_master_if.master m
);

    localparam int unsigned TMR_W = lcs_max(5, $clog2(lcs_max(REQ_HIGH, REQ_GAP)));

    lcs_state_e            state, state_n;
    logic [LCS_SLOT_W-1:0] slot, slot_n;
    logic                  bank, bank_n;
    logic [LCS_SEL_W-1:0]  sel_n;
    logic [LCS_CNT_W-1:0]  cnt_n;
    logic                  req_n, busy_n, wr_en_n, temp_valid_n, done_n;
    logic [LCS_ADDR_W-1:0] wr_addr_n;
    logic [LCS_DATA_W-1:0] wr_data_n, temp_data_n;
    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_val;
    logic                  tmr_zero;

    lcs_req_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            slot        <= '0;
            bank        <= 1'b0;
            m.req       <= 1'b0;
            m.sel       <= '0;
            m.wrEn      <= 1'b0;
            m.wrAddr    <= '0;
            m.wrData    <= '0;
            m.tempData  <= '0;
            m.tempValid <= 1'b0;
            m.busy      <= 1'b0;
            m.frameDone <= 1'b0;
            m.frameCnt  <= '0;
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            bank        <= bank_n;
            m.req       <= req_n;
            m.sel       <= sel_n;
            m.wrEn      <= wr_en_n;
            m.wrAddr    <= wr_addr_n;
            m.wrData    <= wr_data_n;
            m.tempData  <= temp_data_n;
            m.tempValid <= temp_valid_n;
            m.busy      <= busy_n;
            m.frameDone <= done_n;
            m.frameCnt  <= cnt_n;
        end
    end

    // Next state plus next output values; outputs are registered one cycle later.
    always_comb begin
        state_n      = state;
        slot_n       = slot;
        bank_n       = bank;
        sel_n        = m.sel;
        cnt_n        = m.frameCnt;
        wr_en_n      = 1'b0;
        wr_addr_n    = m.wrAddr;
        wr_data_n    = m.wrData;
        temp_data_n  = m.tempData;
        temp_valid_n = 1'b0;
        done_n       = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        unique case (state)
            ST_IDLE: begin
                if (m.start) begin
                    state_n  = ST_ASSERT;
                    slot_n   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(REQ_HIGH - 1);
                end
            end
            ST_ASSERT: begin
                // Last high cycle: the answer byte is stable, capture it.
                if (tmr_zero) begin
                    state_n   = ST_GAP;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(REQ_GAP - 1);
                    wr_en_n   = 1'b1;
                    wr_data_n = m.dataRx;
                    wr_addr_n = {bank, slot};
                    if (slot == LCS_SLOT_W'(TEMP_SLOT)) begin
                        temp_data_n  = m.dataRx;
                        temp_valid_n = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (slot == LCS_SLOT_W'(NUM_REQ - 1)) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                        cnt_n   = m.frameCnt + LCS_CNT_W'(1);
                        bank_n  = ~bank;
                        sel_n   = (m.sel == LCS_SEL_W'(SEL_MAX)) ? '0 : m.sel + LCS_SEL_W'(1);
                    end else begin
                        state_n  = ST_ASSERT;
                        slot_n   = slot + LCS_SLOT_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(REQ_HIGH - 1);
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        req_n  = (state_n == ST_ASSERT);
        busy_n = (state_n == ST_ASSERT) || (state_n == ST_GAP);
    end

endmodule

// File: tb/tb_lcs_request_master.sv
// Randomised scoreboard bench for lcs_request_master: a responder model pushes the
// expected RAM write per request, an independent monitor checks writes and frame timing.
module tb_lcs_request_master;
    import lcs_pkg::*;

    localparam int unsigned H     = 5;
    localparam int unsigned G     = 7;
    localparam int unsigned NREQ  = LCS_NUM_REQ;
    localparam int unsigned TSLOT = LCS_TEMP_SLOT;
    localparam int unsigned FRAME = NREQ * (H + G);

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       temp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lcs_request_master_if bus();

    lcs_request_master #(
        .NUM_REQ   (NREQ),
        .TEMP_SLOT (TSLOT),
        .REQ_HIGH  (H),
        .REQ_GAP   (G),
        .SEL_MAX   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .m   (bus.master)
    );

    exp_t       sb[$];
    int         nchk = 0;
    int         npass = 0;
    int         mode = 0;
    int         req_idx = 0;
    logic       resp_prev = 1'b0;
    logic       mon_prev = 1'b0;
    logic       started = 1'b0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         hi = 0;
    int         lo = 0;
    int         nwr = 0;
    logic       exp_bank = 1'b0;
    logic [2:0] exp_sel = 3'd0;
    logic [4:0] exp_cnt = 5'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"},       32'(bus.req),       0);
        chk({tag, "_busy"},      32'(bus.busy),      0);
        chk({tag, "_wrEn"},      32'(bus.wrEn),      0);
        chk({tag, "_wrAddr"},    32'(bus.wrAddr),    0);
        chk({tag, "_wrData"},    32'(bus.wrData),    0);
        chk({tag, "_tempData"},  32'(bus.tempData),  0);
        chk({tag, "_tempValid"}, 32'(bus.tempValid), 0);
        chk({tag, "_frameDone"}, 32'(bus.frameDone), 0);
        chk({tag, "_frameCnt"},  32'(bus.frameCnt),  0);
        chk({tag, "_sel"},       32'(bus.sel),       0);
    endtask

    // Responder: presents an answer byte on each req rise and records the write it implies.
    initial begin : responder
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                resp_prev = 1'b0;
            end else begin
                if (bus.frameDone) req_idx = 0;
                if (bus.req && !resp_prev) begin
                    case (mode)
                        1:       d = 8'(req_idx + 16);
                        2:       d = (req_idx == int'(TSLOT)) ? 8'hA5 : 8'h00;
                        default: d = 8'($urandom);
                    endcase
                    bus.dataRx = d;
                    sb.push_back('{addr: {exp_bank, 7'(req_idx)}, data: d,
                                   temp: (req_idx == int'(TSLOT))});
                    req_idx++;
                end
                resp_prev = bus.req;
            end
        end
    end

    // Monitor: pulse widths, scoreboard pops on writes, frame-level bookkeeping on frameDone.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                mon_prev = 1'b0; hi = 0; lo = 0; started = 1'b0; nwr = 0;
                exp_bank = 1'b0; exp_sel = 3'd0; exp_cnt = 5'd0;
            end else begin
                if (bus.req && !mon_prev) begin
                    if (!started) begin
                        started  = 1'b1;
                        rise_cyc = cyc;
                    end else begin
                        chk("gap_len", 32'(lo), G);
                    end
                    chk("sel_stable", 32'(bus.sel), 32'(exp_sel));
                    lo = 0;
                end
                if (!bus.req && mon_prev) begin
                    chk("high_len", 32'(hi), H);
                    hi = 0;
                end
                if (bus.req) hi++;
                else if (started) lo++;

                if (bus.wrEn) begin
                    if (sb.size() == 0) begin
                        chk("wr_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_addr", 32'(bus.wrAddr), 32'(e.addr));
                        chk("wr_data", 32'(bus.wrData), 32'(e.data));
                        chk("temp_valid", 32'(bus.tempValid), 32'(e.temp));
                        if (e.temp) chk("temp_data", 32'(bus.tempData), 32'(e.data));
                    end
                    nwr++;
                end else if (bus.tempValid) begin
                    chk("temp_valid_no_wr", 1, 0);
                end

                if (bus.frameDone) begin
                    exp_cnt  = exp_cnt + 5'd1;
                    exp_bank = ~exp_bank;
                    exp_sel  = (exp_sel == 3'd3) ? 3'd0 : exp_sel + 3'd1;
                    chk("frame_len", 32'(cyc - rise_cyc), FRAME);
                    chk("frame_writes", 32'(nwr), NREQ);
                    chk("frame_cnt", 32'(bus.frameCnt), 32'(exp_cnt));
                    chk("busy_at_done", 32'(bus.busy), 0);
                    chk("sb_empty", 32'(sb.size()), 0);
                    started = 1'b0; nwr = 0; lo = 0;
                end
                mon_prev = bus.req;
            end
        end
    end

    task automatic do_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_idx(input int n);
        int k = 0;
        while (req_idx < n && k < int'(FRAME)) begin
            @(negedge clk);
            k++;
        end
        if (req_idx < n) chk("idx_timeout", 32'(req_idx), 32'(n));
    endtask

    task automatic wait_done(input bit pulse_start);
        int k = 0;
        while (!bus.frameDone && k < int'(FRAME) + 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus.frameDone) begin
            chk("done_timeout", 0, 1);
        end else if (pulse_start) begin
            bus.start = 1'b1;
            @(negedge clk) bus.start = 1'b0;
        end
    endtask

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin : main
        int k;
        bus.start  = 1'b0;
        bus.dataRx = 8'h00;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b1;

        // Abort a frame at slot 60 with an asynchronous reset.
        mode = 0;
        do_start();
        wait_idx(61);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_idle_outputs("midreset");
        sb.delete();
        req_idx = 0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        chk("post_reset_frameCnt", 32'(bus.frameCnt), 0);

        // 32 frames: incrementing data, temperature-only, start-ignore, then random.
        for (int f = 1; f <= 32; f++) begin
            mode = (f == 1) ? 1 : (f == 2) ? 2 : 0;
            do_start();
            if (f == 3) begin
                wait_idx(41);
                do_start();
            end
            wait_done(f == 3);
            if (f == 3) begin
                repeat (20) @(negedge clk);
                chk("no_restart_busy", 32'(bus.busy), 0);
                chk("no_restart_reqs", 32'(req_idx), 0);
            end
        end
        chk("wrap_frameCnt", 32'(bus.frameCnt), 0);
        chk("wrap_sel", 32'(bus.sel), 0);

        // First write after the wrap lands in bank 0 at slot 0.
        do_start();
        k = 0;
        while (!bus.wrEn && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wrap_first_addr", 32'(bus.wrAddr), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
